// File: rtl/peridot_pfc_arbiter.sv
// Two-port Avalon-MM arbiter in front of an external bank of PFC registers.
// Each transaction takes three cycles: grant and register in IDLE, drive the
// command and capture the response in ISSUE, then release the winner in DONE.
module peridot_pfc_arbiter #(
    parameter int ARB_MODE  = 0,
    parameter int IDLE_HOLD = 1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [3:0]  avs_s0_address,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    output logic        avs_s0_waitrequest,
    input  logic [3:0]  avs_s1_address,
    input  logic        avs_s1_read,
    input  logic        avs_s1_write,
    input  logic [31:0] avs_s1_writedata,
    output logic [31:0] avs_s1_readdata,
    output logic        avs_s1_waitrequest,
    output logic [36:0] coe_pfc_cmd,
    input  logic [31:0] coe_pfc_resp
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        wr_q, wr_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        req0;
    logic        req1;
    logic        pick1;

    assign req0 = avs_s0_read | avs_s0_write;
    assign req1 = avs_s1_read | avs_s1_write;

    // Choose the winner: on a tie round-robin favours the port not served last,
    // fixed priority always favours s0; a lone requester always wins.
    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1) begin
            if (ARB_MODE == 0) begin
                pick1 = (last_grant_q == 1'b0);
            end else begin
                pick1 = 1'b0;
            end
        end else begin
            pick1 = req1;
        end
    end

    // Next-state logic: IDLE waits for any request, ISSUE and DONE last one cycle each.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req0 || req1) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch the winner's fields at grant, capture the PFC response in ISSUE.
    always_comb begin
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        if (state_q == ST_IDLE && (req0 || req1)) begin
            gnt_d        = pick1;
            last_grant_d = pick1;
            wr_d         = pick1 ? avs_s1_write     : avs_s0_write;
            addr_d       = pick1 ? avs_s1_address   : avs_s0_address;
            wdata_d      = pick1 ? avs_s1_writedata : avs_s0_writedata;
        end
        if (state_q == ST_ISSUE) begin
            if (gnt_q) begin
                rdata1_d = coe_pfc_resp;
            end else begin
                rdata0_d = coe_pfc_resp;
            end
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 4'h0;
            wdata_q      <= 32'h0;
            rdata0_q     <= 32'h0;
            rdata1_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Outputs: the write strobe exists only in ISSUE, only the winner sees DONE.
    always_comb begin
        coe_pfc_cmd        = {1'b0, addr_q, wdata_q};
        avs_s0_waitrequest = 1'b1;
        avs_s1_waitrequest = 1'b1;
        if (state_q == ST_ISSUE) begin
            coe_pfc_cmd[36] = wr_q;
        end
        if (IDLE_HOLD == 0 && state_q == ST_IDLE) begin
            coe_pfc_cmd[35:0] = 36'h0;
        end
        if (state_q == ST_DONE) begin
            if (gnt_q) begin
                avs_s1_waitrequest = 1'b0;
            end else begin
                avs_s0_waitrequest = 1'b0;
            end
        end
    end

    assign avs_s0_readdata = rdata0_q;
    assign avs_s1_readdata = rdata1_q;

endmodule

// File: tb/tb_peridot_pfc_arbiter.sv
// Self-checking bench for peridot_pfc_arbiter: three instances (default,
// fixed priority, no idle hold) share stimulus; each scenario task checks its own.
module tb_peridot_pfc_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  s0_addr, s1_addr;
    logic        s0_rd, s0_wr, s1_rd, s1_wr;
    logic [31:0] s0_wd, s1_wd;
    logic        resp_mode;
    logic [31:0] pfc_const;

    logic [36:0] cmd_a, cmd_f, cmd_h;
    logic [31:0] resp_a, resp_f, resp_h;
    logic [31:0] rd0_a, rd1_a, rd0_f, rd1_f, rd0_h, rd1_h;
    logic        w0_a, w1_a, w0_f, w1_f, w0_h, w1_h;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    // Simple stand-in for the PFC bank: response is a fixed mix of address and data.
    function automatic logic [31:0] pfc_model(input logic [3:0] a, input logic [31:0] wd);
        return wd ^ {28'h5A5AC00, a};
    endfunction

    assign resp_a = resp_mode ? pfc_model(cmd_a[35:32], cmd_a[31:0]) : pfc_const;
    assign resp_f = resp_mode ? pfc_model(cmd_f[35:32], cmd_f[31:0]) : pfc_const;
    assign resp_h = resp_mode ? pfc_model(cmd_h[35:32], cmd_h[31:0]) : pfc_const;

    peridot_pfc_arbiter dut_a (
        .csi_clk(clk), .rsi_reset(rst),
        .avs_s0_address(s0_addr), .avs_s0_read(s0_rd), .avs_s0_write(s0_wr),
        .avs_s0_writedata(s0_wd), .avs_s0_readdata(rd0_a), .avs_s0_waitrequest(w0_a),
        .avs_s1_address(s1_addr), .avs_s1_read(s1_rd), .avs_s1_write(s1_wr),
        .avs_s1_writedata(s1_wd), .avs_s1_readdata(rd1_a), .avs_s1_waitrequest(w1_a),
        .coe_pfc_cmd(cmd_a), .coe_pfc_resp(resp_a)
    );

    peridot_pfc_arbiter #(.ARB_MODE(1)) dut_f (
        .csi_clk(clk), .rsi_reset(rst),
        .avs_s0_address(s0_addr), .avs_s0_read(s0_rd), .avs_s0_write(s0_wr),
        .avs_s0_writedata(s0_wd), .avs_s0_readdata(rd0_f), .avs_s0_waitrequest(w0_f),
        .avs_s1_address(s1_addr), .avs_s1_read(s1_rd), .avs_s1_write(s1_wr),
        .avs_s1_writedata(s1_wd), .avs_s1_readdata(rd1_f), .avs_s1_waitrequest(w1_f),
        .coe_pfc_cmd(cmd_f), .coe_pfc_resp(resp_f)
    );

    peridot_pfc_arbiter #(.IDLE_HOLD(0)) dut_h (
        .csi_clk(clk), .rsi_reset(rst),
        .avs_s0_address(s0_addr), .avs_s0_read(s0_rd), .avs_s0_write(s0_wr),
        .avs_s0_writedata(s0_wd), .avs_s0_readdata(rd0_h), .avs_s0_waitrequest(w0_h),
        .avs_s1_address(s1_addr), .avs_s1_read(s1_rd), .avs_s1_write(s1_wr),
        .avs_s1_writedata(s1_wd), .avs_s1_readdata(rd1_h), .avs_s1_waitrequest(w1_h),
        .coe_pfc_cmd(cmd_h), .coe_pfc_resp(resp_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a scenario stalls on a missing DUT event.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset;
        rst = 1'b1;
        s0_rd = 1'b0; s0_wr = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0;
        s0_addr = 4'h0; s1_addr = 4'h0; s0_wd = 32'h0; s1_wd = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s0_rd = 1'b0; s0_wr = 1'b0; s1_rd = 1'b0; s1_wr = 1'b0;
        s0_addr = 4'h0; s1_addr = 4'h0; s0_wd = 32'h0; s1_wd = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (cmd_a !== 37'h0) begin n_err++; $display("[TB] FAIL reset_cmd: got %h want %h", cmd_a, 37'h0); end
        n_cmp++; if (w0_a !== 1'b1) begin n_err++; $display("[TB] FAIL reset_wait0: got %b want 1", w0_a); end
        n_cmp++; if (w1_a !== 1'b1) begin n_err++; $display("[TB] FAIL reset_wait1: got %b want 1", w1_a); end
        n_cmp++; if (rd0_a !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rd0: got %h want 0", rd0_a); end
        n_cmp++; if (rd1_a !== 32'h0) begin n_err++; $display("[TB] FAIL reset_rd1: got %h want 0", rd1_a); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (w0_a !== 1'b1 || w1_a !== 1'b1) begin n_err++; $display("[TB] FAIL idle_wait: got %b%b want 11", w0_a, w1_a); end
    endtask

    task automatic test_single_read;
        exp_t e;
        apply_reset();
        resp_mode = 1'b0;
        pfc_const = 32'hA5A5_0001;
        s0_addr = 4'h9; s0_rd = 1'b1;
        sb.push_back('{1'b0, 32'hA5A5_0001});
        @(negedge clk);
        n_cmp++; if (cmd_a[35:32] !== 4'h9) begin n_err++; $display("[TB] FAIL read_cmd_addr: got %h want 9", cmd_a[35:32]); end
        n_cmp++; if (cmd_a[36] !== 1'b0) begin n_err++; $display("[TB] FAIL read_cmd_wr: got %b want 0", cmd_a[36]); end
        n_cmp++; if (w0_a !== 1'b1) begin n_err++; $display("[TB] FAIL read_wait_issue: got %b want 1", w0_a); end
        @(negedge clk);
        n_cmp++; if (w0_a !== 1'b0) begin n_err++; $display("[TB] FAIL read_wait_done: got %b want 0", w0_a); end
        n_cmp++; if (w1_a !== 1'b1) begin n_err++; $display("[TB] FAIL read_wait_other: got %b want 1", w1_a); end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("[TB] FAIL read_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            if (rd0_a !== e.data) begin n_err++; $display("[TB] FAIL read_data: got %h want %h", rd0_a, e.data); end
        end
        s0_rd = 1'b0;
        pfc_const = 32'h0BAD_0BAD;
        @(negedge clk);
        n_cmp++; if (w0_a !== 1'b1) begin n_err++; $display("[TB] FAIL read_wait_after: got %b want 1", w0_a); end
        n_cmp++; if (rd0_a !== 32'hA5A5_0001) begin n_err++; $display("[TB] FAIL read_hold: got %h want %h", rd0_a, 32'hA5A5_0001); end
    endtask

    task automatic test_single_write;
        exp_t e;
        apply_reset();
        resp_mode = 1'b1;
        s1_addr = 4'h6; s1_wd = 32'h0011_0000; s1_wr = 1'b1;
        sb.push_back('{1'b1, pfc_model(4'h6, 32'h0011_0000)});
        @(negedge clk);
        n_cmp++; if (cmd_a !== 37'h1600110000) begin n_err++; $display("[TB] FAIL write_cmd: got %h want %h", cmd_a, 37'h1600110000); end
        n_cmp++; if (w1_a !== 1'b1) begin n_err++; $display("[TB] FAIL write_wait_issue: got %b want 1", w1_a); end
        @(negedge clk);
        n_cmp++; if (cmd_a[36] !== 1'b0) begin n_err++; $display("[TB] FAIL write_strobe_done: got %b want 0", cmd_a[36]); end
        n_cmp++; if (w1_a !== 1'b0) begin n_err++; $display("[TB] FAIL write_wait_done: got %b want 0", w1_a); end
        n_cmp++; if (w0_a !== 1'b1) begin n_err++; $display("[TB] FAIL write_wait_other: got %b want 1", w0_a); end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("[TB] FAIL write_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            if (rd1_a !== e.data) begin n_err++; $display("[TB] FAIL write_data: got %h want %h", rd1_a, e.data); end
        end
        n_cmp++; if (rd0_a !== 32'h0) begin n_err++; $display("[TB] FAIL write_rd0_untouched: got %h want 0", rd0_a); end
        s1_wr = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_a !== 37'h0600110000) begin n_err++; $display("[TB] FAIL write_idle_hold: got %h want %h", cmd_a, 37'h0600110000); end
        n_cmp++; if (w1_a !== 1'b1) begin n_err++; $display("[TB] FAIL write_wait_idle: got %b want 1", w1_a); end
    endtask

    task automatic test_reset_in_issue;
        exp_t e;
        resp_mode = 1'b1;
        s0_addr = 4'h3; s0_wd = 32'hDEAD_BEEF; s0_wr = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_a[36] !== 1'b1) begin n_err++; $display("[TB] FAIL rstiss_strobe: got %b want 1", cmd_a[36]); end
        rst = 1'b1;
        s0_wr = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_a !== 37'h0) begin n_err++; $display("[TB] FAIL rstiss_cmd: got %h want 0", cmd_a); end
        n_cmp++; if (w0_a !== 1'b1 || w1_a !== 1'b1) begin n_err++; $display("[TB] FAIL rstiss_wait: got %b%b want 11", w0_a, w1_a); end
        n_cmp++; if (rd0_a !== 32'h0 || rd1_a !== 32'h0) begin n_err++; $display("[TB] FAIL rstiss_rdata: got %h/%h want 0/0", rd0_a, rd1_a); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (w0_a !== 1'b1) begin n_err++; $display("[TB] FAIL rstiss_no_done: got %b want 1", w0_a); end
        s0_wr = 1'b1;
        sb.push_back('{1'b0, pfc_model(4'h3, 32'hDEAD_BEEF)});
        @(negedge clk);
        n_cmp++; if (cmd_a !== 37'h13DEADBEEF) begin n_err++; $display("[TB] FAIL reissue_cmd: got %h want %h", cmd_a, 37'h13DEADBEEF); end
        @(negedge clk);
        n_cmp++; if (w0_a !== 1'b0) begin n_err++; $display("[TB] FAIL reissue_wait: got %b want 0", w0_a); end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("[TB] FAIL reissue_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            if (rd0_a !== e.data) begin n_err++; $display("[TB] FAIL reissue_data: got %h want %h", rd0_a, e.data); end
        end
        s0_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_write_together;
        exp_t e;
        apply_reset();
        resp_mode = 1'b1;
        s0_addr = 4'h5; s0_wd = 32'h0000_00FF; s0_rd = 1'b1; s0_wr = 1'b1;
        sb.push_back('{1'b0, pfc_model(4'h5, 32'h0000_00FF)});
        @(negedge clk);
        n_cmp++; if (cmd_a[36] !== 1'b1) begin n_err++; $display("[TB] FAIL rw_strobe: got %b want 1", cmd_a[36]); end
        n_cmp++; if (cmd_a[35:32] !== 4'h5) begin n_err++; $display("[TB] FAIL rw_addr: got %h want 5", cmd_a[35:32]); end
        @(negedge clk);
        n_cmp++; if (w0_a !== 1'b0) begin n_err++; $display("[TB] FAIL rw_wait: got %b want 0", w0_a); end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("[TB] FAIL rw_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            if (rd0_a !== e.data) begin n_err++; $display("[TB] FAIL rw_data: got %h want %h", rd0_a, e.data); end
        end
        s0_rd = 1'b0; s0_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rr_contention;
        exp_t e;
        int   done_cnt;
        int   last_cyc;
        logic prev36;
        logic got_port;
        logic [31:0] got_data;
        done_cnt = 0; last_cyc = -1; prev36 = 1'b0;
        resp_mode = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        s0_addr = 4'h1; s0_wd = 32'h1111_0000; s0_rd = 1'b1; s0_wr = 1'b0;
        s1_addr = 4'h2; s1_wd = 32'h2222_0000; s1_rd = 1'b1; s1_wr = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sb.push_back('{1'b0, pfc_model(4'h1, 32'h1111_0000)});
            else            sb.push_back('{1'b1, pfc_model(4'h2, 32'h2222_0000)});
        end
        for (int cyc = 0; cyc < 40 && done_cnt < 4; cyc++) begin
            @(negedge clk);
            if (cmd_a[36] && prev36) begin n_err++; $display("[TB] FAIL rr_strobe_consec: got 1 twice want single"); end
            prev36 = cmd_a[36];
            if (!w0_a || !w1_a) begin
                n_cmp++; if (!w0_a && !w1_a) begin n_err++; $display("[TB] FAIL rr_both_done: got 00 want one low"); end
                got_port = w0_a ? 1'b1 : 1'b0;
                got_data = got_port ? rd1_a : rd0_a;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("[TB] FAIL rr_sb: got extra completion want none");
                end else begin
                    e = sb.pop_front();
                    if (got_port !== e.port || got_data !== e.data)
                        begin n_err++; $display("[TB] FAIL rr_order: got s%0d/%h want s%0d/%h", got_port, got_data, e.port, e.data); end
                end
                if (last_cyc >= 0) begin
                    n_cmp++; if (cyc - last_cyc != 3) begin n_err++; $display("[TB] FAIL rr_spacing: got %0d want 3", cyc - last_cyc); end
                end else begin
                    n_cmp++; if (cyc != 1) begin n_err++; $display("[TB] FAIL rr_first_latency: got %0d want 1", cyc); end
                end
                last_cyc = cyc;
                done_cnt++;
                if (done_cnt == 4) begin s0_rd = 1'b0; s1_rd = 1'b0; end
            end
        end
        n_cmp++; if (done_cnt != 4) begin n_err++; $display("[TB] FAIL rr_timeout: got %0d completions want 4", done_cnt); end
        s0_rd = 1'b0; s1_rd = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_fixed_priority;
        exp_t e;
        int   done_cnt;
        int   last_cyc;
        logic got_port;
        logic [31:0] got_data;
        done_cnt = 0; last_cyc = -1;
        resp_mode = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        s0_addr = 4'h1; s0_wd = 32'h1111_0000; s0_rd = 1'b1; s0_wr = 1'b0;
        s1_addr = 4'h2; s1_wd = 32'h2222_0000; s1_rd = 1'b1; s1_wr = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back('{1'b0, pfc_model(4'h1, 32'h1111_0000)});
        sb.push_back('{1'b1, pfc_model(4'h2, 32'h2222_0000)});
        for (int cyc = 0; cyc < 50 && done_cnt < 5; cyc++) begin
            @(negedge clk);
            if (!w0_f || !w1_f) begin
                got_port = w0_f ? 1'b1 : 1'b0;
                got_data = got_port ? rd1_f : rd0_f;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("[TB] FAIL fp_sb: got extra completion want none");
                end else begin
                    e = sb.pop_front();
                    if (got_port !== e.port || got_data !== e.data)
                        begin n_err++; $display("[TB] FAIL fp_order: got s%0d/%h want s%0d/%h", got_port, got_data, e.port, e.data); end
                end
                if (last_cyc >= 0) begin
                    n_cmp++; if (cyc - last_cyc != 3) begin n_err++; $display("[TB] FAIL fp_spacing: got %0d want 3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                done_cnt++;
                if (done_cnt == 4) s0_rd = 1'b0;
                if (done_cnt == 5) s1_rd = 1'b0;
            end
        end
        n_cmp++; if (done_cnt != 5) begin n_err++; $display("[TB] FAIL fp_timeout: got %0d completions want 5", done_cnt); end
        s0_rd = 1'b0; s1_rd = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_idle_hold_off;
        exp_t e;
        apply_reset();
        resp_mode = 1'b1;
        n_cmp++; if (cmd_h !== 37'h0) begin n_err++; $display("[TB] FAIL nohold_reset: got %h want 0", cmd_h); end
        s0_addr = 4'hA; s0_wd = 32'h1234_5678; s0_wr = 1'b1;
        sb.push_back('{1'b0, pfc_model(4'hA, 32'h1234_5678)});
        @(negedge clk);
        n_cmp++; if (cmd_h !== 37'h1A12345678) begin n_err++; $display("[TB] FAIL nohold_issue: got %h want %h", cmd_h, 37'h1A12345678); end
        @(negedge clk);
        n_cmp++; if (w0_h !== 1'b0) begin n_err++; $display("[TB] FAIL nohold_wait: got %b want 0", w0_h); end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("[TB] FAIL nohold_sb: got empty scoreboard want entry");
        end else begin
            e = sb.pop_front();
            if (rd0_h !== e.data) begin n_err++; $display("[TB] FAIL nohold_data: got %h want %h", rd0_h, e.data); end
        end
        s0_wr = 1'b0;
        @(negedge clk);
        n_cmp++; if (cmd_h[35:0] !== 36'h0) begin n_err++; $display("[TB] FAIL nohold_idle: got %h want 0", cmd_h[35:0]); end
        n_cmp++; if (cmd_a[35:0] !== 36'hA12345678) begin n_err++; $display("[TB] FAIL hold_idle: got %h want %h", cmd_a[35:0], 36'hA12345678); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        resp_mode = 1'b0; pfc_const = 32'h0;
        test_reset();
        test_single_read();
        test_single_write();
        test_reset_in_issue();
        test_read_write_together();
        test_rr_contention();
        test_fixed_priority();
        test_idle_hold_off();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("[TB] FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
